// File: rtl/sipo_shift_deser_reg_pkg.sv
// Shared definitions for the serial-in parallel-out deserializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sipo_shift_deser_reg_pkg;

  localparam int SER_WIDTH = 8;

  typedef enum logic {
    ORDER_LSB = 1'b0,
    ORDER_MSB = 1'b1
  } bit_order_t;

  // Width of a counter that holds 0..w-1
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_shift_deser_reg_bit_counter.sv
// Wrapping 0..WIDTH-1 bit counter with a registered busy flag.
// Latency: count and busy update on the edge that advances or clears.
// Backpressure: none; advances only when told to, clear wins over advance.
module deser_bit_counter
  import sipo_shift_deser_reg_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  input  logic clear,
  output logic last_bit,
  output logic busy
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt;

  // Current count points at the final bit of the word
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Count accepted bits, wrap on the last one; busy tracks a non-zero count
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (advance) begin
      if (last_bit) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt  <= cnt + 1'b1;
        busy <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_shift_deser_reg.sv
// Serial-in parallel-out deserializer, MSB- or LSB-first, with a one-word output buffer.
// Latency: out_valid rises the cycle after the edge accepting the last bit.
// Backpressure: output is valid/ready; a word completing into a full, undrained buffer is dropped and sets sticky overrun.
module sipo_shift_deser_reg
  import sipo_shift_deser_reg_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             msb_first,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  bit_order_t       order_q;
  bit_order_t       order_eff;
  logic             accept;
  logic             first_bit;
  logic             last_bit;
  logic             complete;
  logic             drain;

  // Flush discards any bit presented on the same edge
  assign accept    = bit_valid && !flush;
  assign first_bit = !busy;
  assign complete  = accept && last_bit;
  assign drain     = out_valid && out_ready;

  // Bit order is taken live on bit 0, then from the latch for the rest of the word
  assign order_eff = first_bit ? bit_order_t'(msb_first) : order_q;

  // Next shift-register value for the bit being accepted
  always_comb begin
    sr_next = sr;
    if (order_eff == ORDER_MSB) begin
      sr_next = {sr[WIDTH-2:0], serial_in};
    end else begin
      sr_next = {serial_in, sr[WIDTH-1:1]};
    end
  end

  deser_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .clear   (flush),
    .last_bit(last_bit),
    .busy    (busy)
  );

  // Shift register and order latch; flush clears the partial word
  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      order_q <= ORDER_MSB;
    end else if (flush) begin
      sr <= '0;
    end else if (accept) begin
      sr <= sr_next;
      if (first_bit) begin
        order_q <= bit_order_t'(msb_first);
      end
    end
  end

  // Output buffer and overrun: load on completion if the slot is free or draining now
  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (complete) begin
        if (!out_valid || out_ready) begin
          q         <= sr_next;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (flush) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
